// File: rtl/mips_mem_arbiter_if.sv
// Core-side and memory-side signal bundle for mips_mem_arbiter.
// The arbiter uses the slave modport; the core/memory environment uses master.
interface mips_mem_arbiter_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
);
  logic                  if_req;
  logic [ADDR_W-1:0]     if_addr;
  logic [XLEN-1:0]       if_rdata;
  logic                  if_ack;
  logic                  d_req;
  logic                  d_we;
  logic [XLEN/8-1:0]     d_be;
  logic [ADDR_W-1:0]     d_addr;
  logic [XLEN-1:0]       d_wdata;
  logic [XLEN-1:0]       d_rdata;
  logic                  d_ack;
  logic                  stall;
  logic                  mem_req;
  logic                  mem_we;
  logic [XLEN/8-1:0]     mem_be;
  logic [ADDR_W-1:0]     mem_addr;
  logic [XLEN-1:0]       mem_wdata;
  logic [XLEN-1:0]       mem_rdata;
  logic                  mem_ack;
  logic                  bus_err;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_rdata, mem_ack,
    output if_rdata, if_ack, d_rdata, d_ack, stall,
           mem_req, mem_we, mem_be, mem_addr, mem_wdata, bus_err
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_rdata, mem_ack,
    input  if_rdata, if_ack, d_rdata, d_ack, stall,
           mem_req, mem_we, mem_be, mem_addr, mem_wdata, bus_err
  );
endinterface

// File: rtl/mips_mem_arbiter.sv
// Serialises MIPS fetch and data channels onto one req/ack memory port (data first).
// Optional macro MIPS_MEM_TIMEOUT_EN adds a MAX_WAIT cycle timeout with sticky bus_err.
module mips_mem_arbiter #(
  parameter int XLEN     = 32,
  parameter int ADDR_W   = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic               clk,
  input  logic               reset_n,
  mips_mem_arbiter_if.slave  bus
);

  localparam int BE_W = XLEN / 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  if (MAX_WAIT < 1) begin : g_bad_max_wait
    $error("mips_mem_arbiter: MAX_WAIT must be at least 1");
  end
  if ((XLEN % 8) != 0) begin : g_bad_xlen
    $error("mips_mem_arbiter: XLEN must be a multiple of 8");
  end

  state_e             state_q, state_d;
  logic               grant_q, grant_d;
  logic               we_q, we_d;
  logic [BE_W-1:0]    be_q, be_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [XLEN-1:0]    wdata_q, wdata_d;
  logic [XLEN-1:0]    if_rdata_q, if_rdata_d;
  logic [XLEN-1:0]    d_rdata_q, d_rdata_d;
  logic               mem_req_s, if_ack_s, d_ack_s;
  logic               timeout_s;

`ifdef MIPS_MEM_TIMEOUT_EN
  localparam int CNT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
  localparam int REP   = (XLEN + 31) / 32;

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               bus_err_q, bus_err_d;

  function automatic logic [XLEN-1:0] deadbeef_fill();
    logic [REP*32-1:0] w;
    w = {REP{32'hDEADBEEF}};
    return w[XLEN-1:0];
  endfunction

  // The last permitted wait cycle without an ack ends the access.
  assign timeout_s = (state_q == ISSUE) && !bus.mem_ack &&
                     (cnt_q == CNT_W'(MAX_WAIT - 1));

  // Wait counter is zero outside ISSUE, so it is cleared on every entry.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q != ISSUE) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (!bus.mem_ack) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q     <= {CNT_W{1'b0}};
      bus_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign bus.bus_err = bus_err_q;
`else
  assign timeout_s   = 1'b0;
  assign bus.bus_err = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.d_req || bus.if_req) begin
          state_d = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        if (bus.mem_ack || timeout_s) begin
          state_d = RESP;
        end else begin
          state_d = ISSUE;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: acks only in RESP, so mem_ack outside ISSUE has no effect.
  always_comb begin
    mem_req_s = 1'b0;
    if_ack_s  = 1'b0;
    d_ack_s   = 1'b0;
    case (state_q)
      ISSUE: mem_req_s = 1'b1;
      RESP: begin
        if (grant_q == GRANT_D) begin
          d_ack_s = 1'b1;
        end else begin
          if_ack_s = 1'b1;
        end
      end
      default: mem_req_s = 1'b0;
    endcase
  end

  // Request latching in IDLE and read-data capture in ISSUE.
  always_comb begin
    grant_d    = grant_q;
    we_d       = we_q;
    be_d       = be_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
`ifdef MIPS_MEM_TIMEOUT_EN
    bus_err_d  = bus_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.d_req) begin
          grant_d = GRANT_D;
          we_d    = bus.d_we;
          be_d    = bus.d_be;
          addr_d  = bus.d_addr;
          wdata_d = bus.d_wdata;
        end else if (bus.if_req) begin
          grant_d = GRANT_I;
          we_d    = 1'b0;
          be_d    = {BE_W{1'b1}};
          addr_d  = bus.if_addr;
          wdata_d = {XLEN{1'b0}};
        end else begin
          grant_d = grant_q;
        end
      end
      ISSUE: begin
        if (bus.mem_ack) begin
          if (grant_q == GRANT_D) begin
            if (!we_q) begin
              d_rdata_d = bus.mem_rdata;
            end else begin
              d_rdata_d = d_rdata_q;
            end
          end else begin
            if_rdata_d = bus.mem_rdata;
          end
        end
`ifdef MIPS_MEM_TIMEOUT_EN
        else if (timeout_s) begin
          bus_err_d = 1'b1;
          if (grant_q == GRANT_D) begin
            d_rdata_d = deadbeef_fill();
          end else begin
            if_rdata_d = deadbeef_fill();
          end
        end
`endif
        else begin
          grant_d = grant_q;
        end
      end
      default: grant_d = grant_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grant_q    <= GRANT_I;
      we_q       <= 1'b0;
      be_q       <= {BE_W{1'b0}};
      addr_q     <= {ADDR_W{1'b0}};
      wdata_q    <= {XLEN{1'b0}};
      if_rdata_q <= {XLEN{1'b0}};
      d_rdata_q  <= {XLEN{1'b0}};
    end else begin
      grant_q    <= grant_d;
      we_q       <= we_d;
      be_q       <= be_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  assign bus.mem_req   = mem_req_s;
  assign bus.mem_we    = we_q;
  assign bus.mem_be    = be_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.if_ack    = if_ack_s;
  assign bus.d_ack     = d_ack_s;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;

  // Gated by reset_n so every output is low while reset is held.
  assign bus.stall = reset_n & ((bus.if_req & ~if_ack_s) | (bus.d_req & ~d_ack_s));

endmodule
